// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage and register_file users.
package operand_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ModeUsr = 3'b000,
    ModeSys = 3'b001,
    ModeFiq = 3'b010,
    ModeIrq = 3'b011,
    ModeSvc = 3'b100,
    ModeAbt = 3'b101,
    ModeUnd = 3'b110
  } mode_e;

  localparam logic [3:0] REG_PC    = 4'd15;
  localparam logic [1:0] SLOT_RN   = 2'd0;
  localparam logic [1:0] SLOT_RM   = 2'd1;
  localparam logic [1:0] SLOT_RS   = 2'd2;
  localparam logic [1:0] SLOT_NONE = 2'd3;

  // First used slot at or after 'from'; SLOT_NONE when the rest of the list is empty.
  function automatic logic [1:0] next_slot(input logic [2:0] use_mask, input logic [1:0] from);
    next_slot = SLOT_NONE;
    for (int i = 2; i >= 0; i--) begin
      if (use_mask[i] && (2'(i) >= from)) next_slot = 2'(i);
    end
  endfunction

endpackage

// File: rtl/operand_fetch_slot.sv
// One captured operand; priority is reset/clear > forward > capture > hold.
module operand_fetch_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        fwd_en,
  input  logic [31:0] fwd_value,
  input  logic        cap_en,
  input  logic [31:0] cap_value,
  output logic [31:0] value
);

  logic [31:0] value_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value_q <= 32'd0;
    end else if (fwd_en) begin
      value_q <= fwd_value;
    end else if (cap_en) begin
      value_q <= cap_value;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/operand_fetch.sv
// Serialises Rn/Rm/Rs/CPSR reads over the single register_file port and presents one bundle.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter logic [31:0] PC_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rm,
  input  logic [3:0]  req_rs,
  input  logic        req_use_rn,
  input  logic        req_use_rm,
  input  logic        req_use_rs,
  input  logic        req_need_cpsr,
  output logic        rf_read_en,
  output logic [3:0]  rf_read_reg,
  input  logic [31:0] rf_read_value,
  output logic        rf_cpsr_read_en,
  input  logic [31:0] rf_cpsr_value,
  input  logic        wb_en,
  input  logic [3:0]  wb_reg,
  input  logic [31:0] wb_value,
  input  logic        flush,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_rn_val,
  output logic [31:0] op_rm_val,
  output logic [31:0] op_rs_val,
  output logic [31:0] op_cpsr
);

  function automatic logic [3:0] reg_of(input logic [11:0] regs, input logic [1:0] idx);
    case (idx)
      SLOT_RN: reg_of = regs[3:0];
      SLOT_RM: reg_of = regs[7:4];
      default: reg_of = regs[11:8];
    endcase
  endfunction

  state_e      state_q;
  logic [2:0]  use_q;
  logic [11:0] regs_q;
  logic [1:0]  ptr_q;
  logic        rd_en_q, cpsr_en_q, req_ready_q, op_valid_q;
  logic [3:0]  rd_reg_q;
  logic [1:0]  rd_slot_q;
  // Capture stage: describes the read issued in the previous cycle.
  logic        cap_en_q, cpsr_cap_q, hit_q;
  logic [1:0]  cap_slot_q;
  logic [31:0] hit_val_q;
  logic [2:0]  captured_q;
  logic [31:0] cpsr_q;

  logic [2:0]  req_use;
  logic [11:0] req_regs;
  logic [1:0]  first_slot, nxt_slot;
  logic        accept;
  logic [31:0] cap_value;
  logic [2:0]  cap_mask;
  logic [31:0] slot_val [3];

  assign req_use    = {req_use_rs, req_use_rm, req_use_rn};
  assign req_regs   = {req_rs, req_rm, req_rn};
  assign first_slot = next_slot(req_use, 2'd0);
  assign nxt_slot   = next_slot(use_q, ptr_q + 2'd1);
  assign accept     = (state_q == StIdle) && req_valid && req_ready_q && !flush;
  assign cap_mask   = 3'b001 << cap_slot_q;

  // A write that coincided with the read wins over the stale value the register file returns.
  always_comb begin
    cap_value = rf_read_value;
    if (hit_q) begin
      cap_value = hit_val_q;
    end else if (reg_of(regs_q, cap_slot_q) == REG_PC) begin
      cap_value = rf_read_value + PC_OFFSET;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      use_q       <= 3'b000;
      regs_q      <= 12'd0;
      ptr_q       <= 2'd0;
      rd_en_q     <= 1'b0;
      rd_reg_q    <= 4'd0;
      rd_slot_q   <= 2'd0;
      cpsr_en_q   <= 1'b0;
      req_ready_q <= 1'b1;
      op_valid_q  <= 1'b0;
      cap_en_q    <= 1'b0;
      cap_slot_q  <= 2'd0;
      cpsr_cap_q  <= 1'b0;
      hit_q       <= 1'b0;
      hit_val_q   <= 32'd0;
      captured_q  <= 3'b000;
    end else if (flush) begin
      state_q     <= StIdle;
      rd_en_q     <= 1'b0;
      cpsr_en_q   <= 1'b0;
      req_ready_q <= 1'b1;
      op_valid_q  <= 1'b0;
      cap_en_q    <= 1'b0;
      cpsr_cap_q  <= 1'b0;
      hit_q       <= 1'b0;
      captured_q  <= 3'b000;
    end else begin
      cap_en_q   <= rd_en_q;
      cap_slot_q <= rd_slot_q;
      cpsr_cap_q <= cpsr_en_q;
      hit_q      <= rd_en_q && wb_en && (wb_reg == rd_reg_q) && (rd_reg_q != REG_PC);
      hit_val_q  <= wb_value;
      if (cap_en_q) captured_q <= captured_q | cap_mask;

      case (state_q)
        StIdle: begin
          if (accept) begin
            use_q       <= req_use;
            regs_q      <= req_regs;
            captured_q  <= 3'b000;
            req_ready_q <= 1'b0;
            if (first_slot == SLOT_NONE) begin
              rd_en_q    <= 1'b0;
              cpsr_en_q  <= req_need_cpsr;
              state_q    <= req_need_cpsr ? StIssue : StDone;
              op_valid_q <= !req_need_cpsr;
            end else begin
              rd_en_q   <= 1'b1;
              rd_reg_q  <= reg_of(req_regs, first_slot);
              rd_slot_q <= first_slot;
              ptr_q     <= first_slot;
              cpsr_en_q <= req_need_cpsr;
              state_q   <= StIssue;
            end
          end
        end
        StIssue: begin
          cpsr_en_q <= 1'b0;
          if (nxt_slot == SLOT_NONE) begin
            rd_en_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            rd_en_q   <= 1'b1;
            rd_reg_q  <= reg_of(regs_q, nxt_slot);
            rd_slot_q <= nxt_slot;
            ptr_q     <= nxt_slot;
          end
        end
        StDrain: begin
          state_q    <= StDone;
          op_valid_q <= 1'b1;
        end
        default: begin
          if (op_ready) begin
            state_q     <= StIdle;
            op_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush || accept) begin
      cpsr_q <= 32'd0;
    end else if (cpsr_cap_q) begin
      cpsr_q <= rf_cpsr_value;
    end
  end

  for (genvar s = 0; s < 3; s++) begin : g_slot
    logic [3:0] slot_reg;
    logic       capturing, fwd_en;
    assign slot_reg  = regs_q[4*s +: 4];
    assign capturing = cap_en_q && (cap_slot_q == 2'(s));
    // r15 is never forwarded: a PC write flushes the request upstream.
    assign fwd_en    = wb_en && (wb_reg != REG_PC) && (wb_reg == slot_reg) && use_q[s] &&
                       (state_q != StIdle) && (captured_q[s] || capturing);

    operand_fetch_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush || accept),
      .fwd_en    (fwd_en),
      .fwd_value (wb_value),
      .cap_en    (capturing),
      .cap_value (cap_value),
      .value     (slot_val[s])
    );
  end

  assign req_ready       = req_ready_q;
  assign rf_read_en      = rd_en_q;
  assign rf_read_reg     = rd_reg_q;
  assign rf_cpsr_read_en = cpsr_en_q;
  assign op_valid        = op_valid_q;
  assign op_rn_val       = slot_val[SLOT_RN];
  assign op_rm_val       = slot_val[SLOT_RM];
  assign op_rs_val       = slot_val[SLOT_RS];
  assign op_cpsr         = cpsr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a one-cycle-latency register_file model.
module tb_operand_fetch;

  localparam logic [31:0] CpsrVal = 32'h6000_0013;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready;
  logic [3:0]  req_rn, req_rm, req_rs;
  logic        req_use_rn, req_use_rm, req_use_rs, req_need_cpsr;
  logic        rf_read_en, rf_cpsr_read_en;
  logic [3:0]  rf_read_reg;
  logic [31:0] rf_read_value, rf_cpsr_value;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_value;
  logic        flush, op_valid, op_ready;
  logic [31:0] op_rn_val, op_rm_val, op_rs_val, op_cpsr;
  logic [31:0] mem [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rn          (req_rn),
    .req_rm          (req_rm),
    .req_rs          (req_rs),
    .req_use_rn      (req_use_rn),
    .req_use_rm      (req_use_rm),
    .req_use_rs      (req_use_rs),
    .req_need_cpsr   (req_need_cpsr),
    .rf_read_en      (rf_read_en),
    .rf_read_reg     (rf_read_reg),
    .rf_read_value   (rf_read_value),
    .rf_cpsr_read_en (rf_cpsr_read_en),
    .rf_cpsr_value   (rf_cpsr_value),
    .wb_en           (wb_en),
    .wb_reg          (wb_reg),
    .wb_value        (wb_value),
    .flush           (flush),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_rn_val       (op_rn_val),
    .op_rm_val       (op_rm_val),
    .op_rs_val       (op_rs_val),
    .op_cpsr         (op_cpsr)
  );

  // Register file: reads return the pre-write value when coincident with a write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h11 * i;
      mem[15] <= 32'h100;
    end else if (wb_en) begin
      mem[wb_reg] <= wb_value;
    end
    if (rf_read_en) rf_read_value <= mem[rf_read_reg];
    if (rf_cpsr_read_en) rf_cpsr_value <= CpsrVal;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted on the next edge; returns in cycle 1.
  task automatic issue(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs,
                       input logic [2:0] use_mask, input logic cpsr);
    req_rn = rn; req_rm = rm; req_rs = rs;
    {req_use_rs, req_use_rm, req_use_rn} = use_mask;
    req_need_cpsr = cpsr;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic release_bundle(input string tag);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, {31'd0, op_valid}, 32'd0);
    check_eq({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic abort_test(input string tag, input logic use_rst);
    issue(4'd1, 4'd2, 4'd3, 3'b111, 1'b0);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    req_valid = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
    check_eq({tag, "_abort_ready"}, {31'd0, req_ready}, 32'd1);
    check_eq({tag, "_abort_rd_en"}, {31'd0, rf_read_en}, 32'd0);
    tick();
    check_eq({tag, "_abort_no_valid"}, {31'd0, op_valid}, 32'd0);
    check_eq({tag, "_abort_rn_zero"}, op_rn_val, 32'd0);
    issue(4'd1, 4'd0, 4'd0, 3'b001, 1'b0);
    tick(); tick();
    check_eq({tag, "_after_valid"}, {31'd0, op_valid}, 32'd1);
    check_eq({tag, "_after_rn"}, op_rn_val, 32'h11);
    check_eq({tag, "_after_rm"}, op_rm_val, 32'd0);
    release_bundle({tag, "_after"});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; op_ready = 1'b0;
    req_rn = 4'd0; req_rm = 4'd0; req_rs = 4'd0;
    req_use_rn = 1'b0; req_use_rm = 1'b0; req_use_rs = 1'b0; req_need_cpsr = 1'b0;
    wb_en = 1'b0; wb_reg = 4'd0; wb_value = 32'd0;
    tick(); tick();
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check_eq("rst_rd_en", {31'd0, rf_read_en}, 32'd0);
    check_eq("rst_cpsr_en", {31'd0, rf_cpsr_read_en}, 32'd0);
    check_eq("rst_op_data", op_rn_val | op_rm_val | op_rs_val | op_cpsr, 32'd0);
    rst = 1'b0;
    tick();

    // Three reads in order, bundle on cycle 5.
    issue(4'd1, 4'd2, 4'd3, 3'b111, 1'b0);
    check_eq("t1_c1_reg", {27'd0, rf_read_en, rf_read_reg}, {27'd0, 1'b1, 4'd1});
    check_eq("t1_c1_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check_eq("t1_c2_reg", {27'd0, rf_read_en, rf_read_reg}, {27'd0, 1'b1, 4'd2});
    tick();
    check_eq("t1_c3_reg", {27'd0, rf_read_en, rf_read_reg}, {27'd0, 1'b1, 4'd3});
    tick();
    check_eq("t1_c4_rd_en", {31'd0, rf_read_en}, 32'd0);
    check_eq("t1_c4_valid", {31'd0, op_valid}, 32'd0);
    tick();
    check_eq("t1_c5_valid", {31'd0, op_valid}, 32'd1);
    check_eq("t1_rn", op_rn_val, 32'h11);
    check_eq("t1_rm", op_rm_val, 32'h22);
    check_eq("t1_rs", op_rs_val, 32'h33);
    release_bundle("t1");

    // r15 in Rm only gets the pipeline offset.
    issue(4'd0, 4'd15, 4'd0, 3'b010, 1'b0);
    check_eq("t2_c1_reg", {27'd0, rf_read_en, rf_read_reg}, {27'd0, 1'b1, 4'd15});
    tick();
    check_eq("t2_c2_valid", {31'd0, op_valid}, 32'd0);
    tick();
    check_eq("t2_c3_valid", {31'd0, op_valid}, 32'd1);
    check_eq("t2_rm", op_rm_val, 32'h108);
    check_eq("t2_rn_rs", op_rn_val | op_rs_val, 32'd0);
    release_bundle("t2");

    // CPSR only.
    issue(4'd0, 4'd0, 4'd0, 3'b000, 1'b1);
    check_eq("t3_c1_en", {30'd0, rf_cpsr_read_en, rf_read_en}, 32'd2);
    tick();
    check_eq("t3_c2_en", {30'd0, rf_cpsr_read_en, op_valid}, 32'd0);
    tick();
    check_eq("t3_c3_valid", {31'd0, op_valid}, 32'd1);
    check_eq("t3_cpsr", op_cpsr, CpsrVal);
    release_bundle("t3");

    // Nothing requested: bundle one cycle after accept.
    issue(4'd0, 4'd0, 4'd0, 3'b000, 1'b0);
    check_eq("t0_valid", {31'd0, op_valid}, 32'd1);
    check_eq("t0_data", op_rn_val | op_rm_val | op_rs_val | op_cpsr, 32'd0);
    release_bundle("t0");

    // Write coincident with the read, then forwarding in DONE; r15 write ignored.
    issue(4'd4, 4'd0, 4'd0, 3'b001, 1'b0);
    wb_en = 1'b1; wb_reg = 4'd4; wb_value = 32'hDEAD;
    tick();
    wb_en = 1'b0;
    tick();
    check_eq("t4_valid", {31'd0, op_valid}, 32'd1);
    check_eq("t4_rn_same_cycle", op_rn_val, 32'hDEAD);
    wb_en = 1'b1; wb_value = 32'hBEEF;
    tick();
    check_eq("t4_rn_done_fwd", op_rn_val, 32'hBEEF);
    wb_reg = 4'd15; wb_value = 32'h999;
    tick();
    wb_en = 1'b0;
    check_eq("t4_rn_pc_ignored", op_rn_val, 32'hBEEF);
    check_eq("t4_rm_unused", op_rm_val, 32'd0);
    release_bundle("t4");

    // Write during the capture cycle of the previous read.
    issue(4'd5, 4'd0, 4'd0, 3'b001, 1'b0);
    tick();
    wb_en = 1'b1; wb_reg = 4'd5; wb_value = 32'h5A5A;
    tick();
    wb_en = 1'b0;
    check_eq("t4b_rn_cap_fwd", op_rn_val, 32'h5A5A);
    release_bundle("t4b");

    // Two slots naming r6 update together.
    issue(4'd6, 4'd6, 4'd0, 3'b011, 1'b0);
    tick(); tick(); tick();
    check_eq("t4c_both", {op_rn_val[15:0], op_rm_val[15:0]}, 32'h0066_0066);
    wb_en = 1'b1; wb_reg = 4'd6; wb_value = 32'h1234;
    tick();
    wb_en = 1'b0;
    check_eq("t4c_both_fwd", {op_rn_val[15:0], op_rm_val[15:0]}, 32'h1234_1234);
    release_bundle("t4c");

    // Back-pressure in DONE with CPSR and a skipped middle slot.
    issue(4'd1, 4'd9, 4'd3, 3'b101, 1'b1);
    check_eq("t5_c1_cpsr_en", {31'd0, rf_cpsr_read_en}, 32'd1);
    tick();
    check_eq("t5_c2_reg", {27'd0, rf_read_en, rf_read_reg}, {27'd0, 1'b1, 4'd3});
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_hold_valid", {31'd0, op_valid}, 32'd1);
      check_eq("t5_hold_ready", {31'd0, req_ready}, 32'd0);
      check_eq("t5_hold_data", op_rn_val ^ op_rm_val ^ op_rs_val, 32'h11 ^ 32'h33);
      check_eq("t5_hold_cpsr", op_cpsr, CpsrVal);
      tick();
    end
    release_bundle("t5");

    abort_test("t6_flush", 1'b0);
    abort_test("t6_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
